// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl
//   Sequences TLBSRCH / TLBRD / TLBWR / TLBFILL / INVTLB from EX onto the
//   TLB's search-1, read, write and invalidate ports. It also shares search
//   port 1 with the load/store translation path, generates the TLBFILL
//   replacement index, and returns one result packet per accepted operation.
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   op_valid/op_ready              operation request handshake from EX
//   op_code, op_inv_*              operation and INVTLB operands
//   csr_index/csr_asid/csr_vppn    TLBIDX.Index, ASID.ASID, TLBEHI.VPPN
//   mem_req/mem_vppn/mem_grant     load/store use of search port 1
//   s1_vppn/s1_asid/s1_ps          search port 1 request to the TLB
//   s1_found/s1_index              search port 1 result from the TLB
//   invtlb_valid/invtlb_op         invalidate request to the TLB
//   we/we_index                    TLB write strobe and index
//   r_index                        TLB read index
//   done_valid/done_ready          result packet handshake to the pipeline
//   done_code/hit/index/ex         result packet contents
//   dbg_state, dbg_fill_ptr        FSM state and replacement pointer
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. op_ready is 1 only in IDLE. done_valid is 1 only in DONE and
// the packet stays stable until done_ready is seen; no operation is accepted
// in the same cycle the packet is consumed.

module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [4:0]    op_inv_op,
  input  logic [9:0]    op_inv_asid,
  input  logic [18:0]   op_inv_vppn,
  input  logic [IW-1:0] csr_index,
  input  logic [9:0]    csr_asid,
  input  logic [18:0]   csr_vppn,
  input  logic          mem_req,
  input  logic [18:0]   mem_vppn,
  output logic          mem_grant,
  output logic [18:0]   s1_vppn,
  output logic [9:0]    s1_asid,
  output logic [5:0]    s1_ps,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  output logic          invtlb_valid,
  output logic [4:0]    invtlb_op,
  output logic          we,
  output logic [IW-1:0] we_index,
  output logic [IW-1:0] r_index,
  output logic          done_valid,
  input  logic          done_ready,
  output logic [2:0]    done_code,
  output logic          done_hit,
  output logic [IW-1:0] done_index,
  output logic          done_ex,
  output logic [1:0]    dbg_state,
  output logic [IW-1:0] dbg_fill_ptr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_SRCH = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_FILL = 3'd4;
  localparam logic [2:0] OP_INV  = 3'd5;

  state_t        state_q, state_d;
  logic [2:0]    code_q;
  logic [4:0]    inv_op_q;
  logic [9:0]    inv_asid_q;
  logic [18:0]   inv_vppn_q;
  logic [IW-1:0] fill_ptr;
  logic          res_hit_q;
  logic [IW-1:0] res_index_q;
  logic          res_ex_q;

  // Decode of the latched operation
  logic is_srch, is_rd, is_wr, is_fill, is_inv, inv_legal, op_ex;
  logic in_exec, port1_busy;

  assign is_srch   = (code_q == OP_SRCH);
  assign is_rd     = (code_q == OP_RD);
  assign is_wr     = (code_q == OP_WR);
  assign is_fill   = (code_q == OP_FILL);
  assign is_inv    = (code_q == OP_INV);
  assign inv_legal = is_inv && (inv_op_q <= 5'd6);
  // Anything that is not one of the five legal operations, or an INVTLB
  // with an op field above 6, raises INE and touches no TLB port.
  assign op_ex     = !(is_srch || is_rd || is_wr || is_fill || is_inv) ||
                     (is_inv && !inv_legal);

  assign in_exec    = (state_q == EXEC);
  // TLBSRCH and legal INVTLB own search port 1 for their single EXEC cycle.
  assign port1_busy = in_exec && (is_srch || inv_legal);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_valid)   state_d = EXEC;
      EXEC:                    state_d = DONE;
      DONE:    if (done_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Operation latch (IDLE accept) and result capture (end of EXEC)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code_q      <= '0;
      inv_op_q    <= '0;
      inv_asid_q  <= '0;
      inv_vppn_q  <= '0;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
      res_ex_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && op_valid) begin
        code_q     <= op_code;
        inv_op_q   <= op_inv_op;
        inv_asid_q <= op_inv_asid;
        inv_vppn_q <= op_inv_vppn;
      end
      if (in_exec) begin
        res_hit_q   <= is_srch && s1_found;
        res_index_q <= is_srch ? s1_index : (is_fill ? fill_ptr : '0);
        res_ex_q    <= op_ex;
      end
    end
  end

  // Free-running replacement pointer; its value in EXEC picks the FILL slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          fill_ptr <= '0;
    else if (fill_ptr == IW'(TLBNUM - 1)) fill_ptr <= '0;
    else                                  fill_ptr <= fill_ptr + 1'b1;
  end

  // Port drive
  always_comb begin
    op_ready     = resetn && (state_q == IDLE);
    mem_grant    = resetn && mem_req && !port1_busy;
    s1_vppn      = '0;
    s1_asid      = '0;
    s1_ps        = '0;
    we           = 1'b0;
    we_index     = '0;
    invtlb_valid = 1'b0;
    invtlb_op    = '0;
    r_index      = '0;

    if (in_exec && is_srch) begin
      s1_vppn = csr_vppn;
      s1_asid = csr_asid;
    end else if (in_exec && inv_legal) begin
      s1_vppn = inv_vppn_q;
      s1_asid = inv_asid_q;
      s1_ps   = 6'd12;
    end else if (mem_grant) begin
      s1_vppn = mem_vppn;
      s1_asid = csr_asid;
    end

    if (in_exec) begin
      if (is_wr) begin
        we       = 1'b1;
        we_index = csr_index;
      end
      if (is_fill) begin
        we       = 1'b1;
        we_index = fill_ptr;
      end
      if (is_rd) r_index = csr_index;
      if (inv_legal) begin
        invtlb_valid = 1'b1;
        invtlb_op    = inv_op_q;
      end
    end
  end

  assign done_valid   = (state_q == DONE);
  assign done_code    = code_q;
  assign done_hit     = res_hit_q;
  assign done_index   = res_index_q;
  assign done_ex      = res_ex_q;
  assign dbg_state    = state_q;
  assign dbg_fill_ptr = fill_ptr;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Testbench for tlb_op_ctrl: a small TLB stand-in answers search port 1 and
// applies writes/invalidates driven by the DUT; a separate reference table,
// updated from the operation rules, predicts every result packet.
module tb_tlb_op_ctrl;
  localparam int TLBNUM = 16;
  localparam int IW     = 4;

  logic          clk, resetn;
  logic          op_valid, op_ready;
  logic [2:0]    op_code;
  logic [4:0]    op_inv_op;
  logic [9:0]    op_inv_asid;
  logic [18:0]   op_inv_vppn;
  logic [IW-1:0] csr_index;
  logic [9:0]    csr_asid;
  logic [18:0]   csr_vppn;
  logic          mem_req, mem_grant;
  logic [18:0]   mem_vppn;
  logic [18:0]   s1_vppn;
  logic [9:0]    s1_asid;
  logic [5:0]    s1_ps;
  logic          s1_found;
  logic [IW-1:0] s1_index;
  logic          invtlb_valid;
  logic [4:0]    invtlb_op;
  logic          we;
  logic [IW-1:0] we_index, r_index;
  logic          done_valid, done_ready;
  logic [2:0]    done_code;
  logic          done_hit;
  logic [IW-1:0] done_index;
  logic          done_ex;
  logic [1:0]    dbg_state;
  logic [IW-1:0] dbg_fill_ptr;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_inv_op(op_inv_op), .op_inv_asid(op_inv_asid), .op_inv_vppn(op_inv_vppn),
    .csr_index(csr_index), .csr_asid(csr_asid), .csr_vppn(csr_vppn),
    .mem_req(mem_req), .mem_vppn(mem_vppn), .mem_grant(mem_grant),
    .s1_vppn(s1_vppn), .s1_asid(s1_asid), .s1_ps(s1_ps),
    .s1_found(s1_found), .s1_index(s1_index),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .we(we), .we_index(we_index), .r_index(r_index),
    .done_valid(done_valid), .done_ready(done_ready), .done_code(done_code),
    .done_hit(done_hit), .done_index(done_index), .done_ex(done_ex),
    .dbg_state(dbg_state), .dbg_fill_ptr(dbg_fill_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges seen since the last reset release: the replacement pointer is
  // this count modulo TLBNUM.
  int unsigned ref_cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) ref_cyc <= 0;
    else         ref_cyc <= ref_cyc + 1;
  end

  // ---------------- TLB model ----------------
  typedef struct packed {
    logic        v;
    logic        g;
    logic [18:0] vppn;
    logic [9:0]  asid;
  } ent_t;

  function automatic logic [IW:0] tlb_search(input ent_t t[TLBNUM], input logic [18:0] vppn,
                                             input logic [9:0] asid);
    for (int i = 0; i < TLBNUM; i++)
      if (t[i].v && t[i].vppn == vppn && (t[i].g || t[i].asid == asid)) return {1'b1, IW'(i)};
    return '0;
  endfunction

  function automatic logic inv_kill(input ent_t e, input logic [4:0] op, input logic [9:0] asid,
                                    input logic [18:0] vppn);
    logic am, vm;
    am = (e.asid == asid);
    vm = (e.vppn == vppn);
    case (op)
      5'd0, 5'd1: return e.v;
      5'd2:       return e.v && e.g;
      5'd3:       return e.v && !e.g;
      5'd4:       return e.v && !e.g && am;
      5'd5:       return e.v && !e.g && am && vm;
      5'd6:       return e.v && (e.g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  // Write data presented to the TLB alongside the operation
  logic        wr_g;
  logic [18:0] wr_vppn;
  logic [9:0]  wr_asid;
  logic        env_clr;
  ent_t        env_tlb[TLBNUM];

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < TLBNUM; i++) env_tlb[i] <= '0;
    end else begin
      if (we) env_tlb[we_index] <= {1'b1, wr_g, wr_vppn, wr_asid};
      if (invtlb_valid)
        for (int i = 0; i < TLBNUM; i++)
          if (inv_kill(env_tlb[i], invtlb_op, s1_asid, s1_vppn)) env_tlb[i].v <= 1'b0;
    end
  end

  always_comb begin : env_srch
    logic [IW:0] r;
    r        = tlb_search(env_tlb, s1_vppn, s1_asid);
    s1_found = r[IW];
    s1_index = r[IW-1:0];
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- background drivers ----------------
  logic        mem_force;
  int unsigned hold_until;

  initial begin
    mem_req = 1'b0; mem_vppn = '0; done_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_req  = mem_force ? 1'b1 : ($urandom_range(0, 1) == 1);
      mem_vppn = 19'($urandom);
      if (ref_cyc < hold_until) done_ready = 1'b0;
      else                      done_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [2:0] code, input logic [4:0] iop, input logic [9:0] ia,
                       input logic [18:0] iv, input logic [IW-1:0] cidx, input logic [9:0] ca,
                       input logic [18:0] cv, input logic wg, input logic [18:0] wv,
                       input logic [9:0] wa);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!op_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        n_checks++; n_errors++;
        $display("FAIL issue_timeout: op_ready stayed 0 for %0d cycles (required 1)", waited);
        return;
      end
    end
    @(posedge clk); #1;
    op_code = code; op_inv_op = iop; op_inv_asid = ia; op_inv_vppn = iv;
    csr_index = cidx; csr_asid = ca; csr_vppn = cv;
    wr_g = wg; wr_vppn = wv; wr_asid = wa;
    op_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [2:0]    code;
    logic          hit;
    logic [IW-1:0] index;
    logic          ex;
    logic [IW-1:0] widx;
    logic [4:0]    inv_op;
    logic [9:0]    asid;
    logic [18:0]   vppn;
    ent_t          wdata;
  } exp_t;

  typedef struct packed {
    logic          we;
    logic [IW-1:0] we_index;
    logic          inv;
    logic [4:0]    inv_op;
    logic [IW-1:0] r_index;
    logic          s1_own;
    logic [18:0]   s1_vppn;
    logic [9:0]    s1_asid;
    logic [5:0]    s1_ps;
  } exec_t;

  exp_t  exp_q[$];
  ent_t  ref_tlb[TLBNUM];
  exec_t exec_pend, exec_cur;

  initial begin : monitor
    exp_t          e;
    logic          legal_inv;
    logic [IW-1:0] fidx;
    for (int i = 0; i < TLBNUM; i++) ref_tlb[i] = '0;
    exec_pend = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        exec_pend = '0;
        continue;
      end
      exec_cur  = exec_pend;
      exec_pend = '0;

      check("fill_ptr", 32'(dbg_fill_ptr), ref_cyc % TLBNUM);

      // TLB port activity expected this cycle (nonzero only in EXEC)
      check("we", 32'(we), 32'(exec_cur.we));
      if (exec_cur.we) check("we_index", 32'(we_index), 32'(exec_cur.we_index));
      check("invtlb_valid", 32'(invtlb_valid), 32'(exec_cur.inv));
      if (exec_cur.inv) check("invtlb_op", 32'(invtlb_op), 32'(exec_cur.inv_op));
      check("r_index", 32'(r_index), 32'(exec_cur.r_index));

      // Search port 1 ownership
      check("mem_grant", 32'(mem_grant), 32'(mem_req & ~exec_cur.s1_own));
      if (exec_cur.s1_own) begin
        check("s1_vppn_op", 32'(s1_vppn), 32'(exec_cur.s1_vppn));
        check("s1_asid_op", 32'(s1_asid), 32'(exec_cur.s1_asid));
        check("s1_ps_op", 32'(s1_ps), 32'(exec_cur.s1_ps));
      end else if (mem_req) begin
        check("s1_vppn_mem", 32'(s1_vppn), 32'(mem_vppn));
        check("s1_asid_mem", 32'(s1_asid), 32'(csr_asid));
      end else begin
        check("s1_vppn_idle", 32'(s1_vppn), 32'd0);
      end

      // Result packet: compared every cycle it is presented, popped on handshake
      if (done_valid) begin
        check("op_ready_in_done", 32'(op_ready), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL done_unexpected: done_valid=1 with no outstanding operation at %0t", $time);
        end else begin
          e = exp_q[0];
          check("done_code", 32'(done_code), 32'(e.code));
          check("done_hit", 32'(done_hit), 32'(e.hit));
          check("done_index", 32'(done_index), 32'(e.index));
          check("done_ex", 32'(done_ex), 32'(e.ex));
          if (done_ready) begin
            void'(exp_q.pop_front());
            if (e.code == 3'd3 || e.code == 3'd4) ref_tlb[e.widx] = e.wdata;
            if (e.code == 3'd5 && e.inv_op <= 5'd6)
              for (int i = 0; i < TLBNUM; i++)
                if (inv_kill(ref_tlb[i], e.inv_op, e.asid, e.vppn)) ref_tlb[i].v = 1'b0;
          end
        end
      end

      // Acceptance: predict the packet and next cycle's port activity
      if (op_valid && op_ready) begin
        fidx      = IW'((ref_cyc + 1) % TLBNUM);
        legal_inv = (op_code == 3'd5) && (op_inv_op <= 5'd6);
        e         = '0;
        e.code    = op_code;
        e.ex      = !(op_code inside {[3'd1:3'd5]}) || (op_code == 3'd5 && !legal_inv);
        if (op_code == 3'd1) {e.hit, e.index} = tlb_search(ref_tlb, csr_vppn, csr_asid);
        if (op_code == 3'd4) e.index = fidx;
        e.widx   = (op_code == 3'd4) ? fidx : csr_index;
        e.inv_op = op_inv_op;
        e.asid   = op_inv_asid;
        e.vppn   = op_inv_vppn;
        e.wdata  = {1'b1, wr_g, wr_vppn, wr_asid};
        exp_q.push_back(e);

        exec_pend.we       = (op_code == 3'd3) || (op_code == 3'd4);
        exec_pend.we_index = (op_code == 3'd4) ? fidx : csr_index;
        exec_pend.inv      = legal_inv;
        exec_pend.inv_op   = op_inv_op;
        exec_pend.r_index  = (op_code == 3'd2) ? csr_index : '0;
        exec_pend.s1_own   = (op_code == 3'd1) || legal_inv;
        exec_pend.s1_vppn  = (op_code == 3'd1) ? csr_vppn : op_inv_vppn;
        exec_pend.s1_asid  = (op_code == 3'd1) ? csr_asid : op_inv_asid;
        exec_pend.s1_ps    = legal_inv ? 6'd12 : 6'd0;
      end
    end
  end

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 || !op_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        n_checks++; n_errors++;
        $display("FAIL drain_timeout: %0d packets outstanding (required 0)", exp_q.size());
        return;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetn = 1'b0; env_clr = 1'b1; mem_force = 1'b0; hold_until = 0;
    op_valid = 1'b0; op_code = '0; op_inv_op = '0; op_inv_asid = '0; op_inv_vppn = '0;
    csr_index = '0; csr_asid = '0; csr_vppn = '0; wr_g = 1'b0; wr_vppn = '0; wr_asid = '0;
    repeat (3) @(posedge clk);
    #1;
    env_clr = 1'b0;
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_mem_grant", 32'(mem_grant), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_done_code", 32'(done_code), 32'd0);
    check("rst_done_index", 32'(done_index), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_fill_ptr", 32'(dbg_fill_ptr), 32'd0);
    resetn = 1'b1;

    // Reset asserted in the middle of a TLBWR EXEC cycle
    issue(3'd3, 5'd0, 10'd0, 19'd0, 4'd5, 10'h001, 19'h00123, 1'b0, 19'h00123, 10'h001);
    check("wr_exec_we", 32'(we), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_we", 32'(we), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("rel_op_ready", 32'(op_ready), 32'd1);
    check("rel_fill_ptr", 32'(dbg_fill_ptr), 32'd0);

    // Directed sequence with load/store always requesting port 1
    mem_force = 1'b1;
    issue(3'd3, 5'd0, 10'd0, 19'd0, 4'd5, 10'h001, 19'h00000, 1'b0, 19'h00123, 10'h001);
    issue(3'd1, 5'd0, 10'd0, 19'd0, 4'd0, 10'h001, 19'h00123, 1'b0, 19'h00000, 10'h000);
    issue(3'd5, 5'd5, 10'h001, 19'h00123, 4'd0, 10'h001, 19'h00000, 1'b0, 19'h00000, 10'h000);
    issue(3'd1, 5'd0, 10'd0, 19'd0, 4'd0, 10'h001, 19'h00123, 1'b0, 19'h00000, 10'h000);
    issue(3'd5, 5'd7, 10'h001, 19'h00123, 4'd0, 10'h001, 19'h00000, 1'b0, 19'h00000, 10'h000);
    issue(3'd0, 5'd0, 10'd0, 19'd0, 4'd0, 10'h000, 19'h00000, 1'b0, 19'h00000, 10'h000);
    issue(3'd6, 5'd0, 10'd0, 19'd0, 4'd0, 10'h000, 19'h00000, 1'b0, 19'h00000, 10'h000);
    issue(3'd7, 5'd0, 10'd0, 19'd0, 4'd0, 10'h000, 19'h00000, 1'b0, 19'h00000, 10'h000);
    issue(3'd2, 5'd0, 10'd0, 19'd0, 4'd9, 10'h000, 19'h00000, 1'b0, 19'h00000, 10'h000);
    drain();
    mem_force = 1'b0;

    // TLBFILL shortly after a fresh reset, result held back by the pipeline
    @(posedge clk); #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    hold_until = ref_cyc + 10;
    issue(3'd4, 5'd0, 10'd0, 19'd0, 4'd0, 10'h002, 19'h00000, 1'b0, 19'h00456, 10'h002);
    drain();

    // Randomized operation mix
    for (int n = 0; n < 300; n++) begin
      logic [2:0] code;
      int         pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    code = 3'd1;
        2:       code = 3'd2;
        3, 4:    code = 3'd3;
        5, 6:    code = 3'd4;
        7, 8:    code = 3'd5;
        default: code = 3'($urandom_range(0, 7));
      endcase
      issue(code, 5'($urandom_range(0, 7)), 10'($urandom_range(0, 2)),
            19'(12'h100 + $urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            10'($urandom_range(0, 2)), 19'(12'h100 + $urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 19'(12'h100 + $urandom_range(0, 3)),
            10'($urandom_range(0, 2)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences the TLB-management instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB from the EX stage onto the TLB's search-1, read, write and invalidate ports.
- Arbitrates search port 1 between the load/store translation path and TLBSRCH/INVTLB.
- Generates the TLBFILL replacement index and returns one result packet per accepted operation to the pipeline.

Parameters:
TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
op_valid  input  1  TLB operation request
op_ready  output  1  controller can accept an operation
op_code  input  3  1 SRCH, 2 RD, 3 WR, 4 FILL, 5 INV; other values are illegal
op_inv_op  input  5  INVTLB op field
op_inv_asid  input  10  INVTLB rj ASID
op_inv_vppn  input  19  INVTLB rk VA[31:13]
csr_index  input  IW  CSR.TLBIDX.Index
csr_asid  input  10  CSR.ASID.ASID
csr_vppn  input  19  CSR.TLBEHI.VPPN
mem_req  input  1  load/store wants search port 1
mem_vppn  input  19  load/store VA[31:13]
mem_grant  output  1  search port 1 carries the load/store lookup this cycle
s1_vppn  output  19  to TLB s1_vppn
s1_asid  output  10  to TLB s1_asid
s1_ps  output  6  to TLB (INVTLB page-size compare)
s1_found  input  1  from TLB
s1_index  input  IW  from TLB
invtlb_valid  output  1  to TLB
invtlb_op  output  5  to TLB
we  output  1  TLB write enable
we_index  output  IW  TLB write index
r_index  output  IW  TLB read index
done_valid  output  1  result packet valid
done_ready  input  1  pipeline consumes the result
done_code  output  3  op_code of the completed operation
done_hit  output  1  SRCH hit (TLBIDX.NE = ~done_hit)
done_index  output  IW  SRCH hit index, or FILL index used
done_ex  output  1  illegal op_code or INVTLB op > 6 (INE exception)

Behaviour:
- FSM states: IDLE, EXEC, DONE. Reset enters IDLE.
- Reset values: every output is 0, fill_ptr = 0, all captured result registers = 0.
- IDLE: op_ready = 1.
  - op_valid = 1: latch op_code, op_inv_op, op_inv_asid and op_inv_vppn, then go to EXEC.
  - Results cannot overlap: op_ready = 0 in EXEC and DONE.
- EXEC lasts exactly 1 cycle. Drives, by op_code:
  - SRCH: s1_vppn = csr_vppn, s1_asid = csr_asid. Capture done_hit = s1_found and done_index = s1_index at the clock edge.
  - RD: r_index = csr_index. The read data path is combinational; the CSR update happens outside the block at DONE.
  - WR: we = 1, we_index = csr_index.
  - FILL: we = 1, we_index = fill_ptr. done_index = fill_ptr.
  - INV with latched op <= 6: invtlb_valid = 1, invtlb_op = latched op, s1_vppn = latched vppn, s1_asid = latched asid, s1_ps = 6'd12.
  - INV with op > 6, or an illegal op_code: no TLB port is asserted; done_ex = 1.
- EXEC always goes to DONE.
- DONE: done_valid = 1 and the outputs are held stable until done_ready = 1. On the handshake, go to IDLE and clear done_valid. Same-cycle re-accept is not allowed.
- Port 1 arbitration:
  - mem_grant = mem_req AND NOT (state == EXEC AND latched op is SRCH or legal INV).
  - When granted, s1_vppn = mem_vppn and s1_asid = csr_asid.
  - When neither user holds the port, s1_vppn and s1_asid are 0.
- we, invtlb_valid and r_index are 0 outside EXEC.
- Fill pointer:
  - Free-running, increments every clk and wraps from TLBNUM-1 to 0. It provides pseudo-random replacement.
  - The value sampled in EXEC is the one used for the write and is reported.
- A resetn assertion in any state returns to IDLE the same instant. No we or invtlb_valid pulse is emitted after reset assertion.
- Writes take effect at the clock edge ending EXEC. A SRCH accepted next therefore sees the new entry.

Test Plan:
- Reset: resetn = 0 mid-EXEC of WR -> we = 0 immediately, state IDLE, op_ready = 1 after release, fill_ptr = 0.
- TLBWR then TLBSRCH:
  - WR with csr_index = 5, the TLB write data mapping vppn 0x00123, asid 0x01 -> we = 1 with we_index = 5 for exactly 1 cycle.
  - Then SRCH with csr_vppn = 0x00123, csr_asid = 0x01 -> done_hit = 1, done_index = 5, done_code = 1.
- Arbitration:
  - mem_req = 1 during SRCH EXEC -> mem_grant = 0 that cycle, 1 the next cycle.
  - mem_req = 1 during WR EXEC -> mem_grant = 1.
- INVTLB op 5 with asid 0x01, vppn 0x00123 after the WR above -> invtlb_valid = 1 for 1 cycle; a following SRCH gives done_hit = 0.
- INVTLB op 7 -> invtlb_valid never asserts; done_ex = 1 with done_code = 5. Illegal op_code 0 -> done_ex = 1.
- TLBFILL:
  - Issue FILL 3 cycles after reset release -> we_index = done_index = fill_ptr value in EXEC.
  - Hold done_ready = 0 for 4 cycles -> done_valid and done_index stay stable, op_ready = 0.
  - Fill pointer wraps 15 -> 0 with TLBNUM = 16.
